// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern, hex glyph table
// (active low, bit order g..a) and a ceil-log2 helper for sizing counters.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Returns at least 1 so single-value counters still get a real bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low segment decoder with a force-blank input.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPH[nibble];
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit hex seven-segment driver with refresh divider, frame-aligned
// shadow capture, anti-ghost blanking and frame strobe. Optional: LEADING_ZERO_BLANK_EN.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [6:0]              out7,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    frame_done
);

  localparam int unsigned TICK_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned DIV_W    = clog2(TICK_DIV);
  localparam int unsigned IDX_W    = clog2(NUM_DIGITS);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] stage_value_q, stage_value_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              out7_q, out7_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       suppress;
  logic [6:0] glyph;

  assign tick = (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign wrap = tick && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d  = digit_idx_q;
    if (wrap) begin
      digit_idx_d = '0;
    end else if (tick) begin
      digit_idx_d = digit_idx_q + 1'b1;
    end
    frame_done_d = wrap;
  end

  // A load coinciding with the wrap bypasses staging so it lands in the frame starting now.
  always_comb begin
    stage_value_d  = stage_value_q;
    stage_dp_d     = stage_dp_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    pending_d      = pending_q;
    if (load) begin
      stage_value_d = value;
      stage_dp_d    = dp;
    end
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_value_d = value;
        shadow_dp_d    = dp;
      end else if (pending_q) begin
        shadow_value_d = stage_value_q;
        shadow_dp_d    = stage_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Enables are computed from next-state counters so the register lines up with the slot.
  always_comb begin
    en_d = '1;
    if (div_cnt_d >= DIV_W'(BLANK_CYCLES)) begin
      en_d[digit_idx_d] = 1'b0;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        cur_nib = shadow_value_q[i*4 +: 4];
        cur_dp  = shadow_dp_q[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; a digit is suppressed while everything at or above it is zero.
  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    suppress = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_above = nz_above | (|shadow_value_q[i*4 +: 4]);
      if ((digit_idx_q == IDX_W'(i)) && (i != 0)) begin
        suppress = !nz_above && !shadow_dp_q[i];
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  hex_to_7seg u_hex_to_7seg (
    .nibble (cur_nib),
    .blank  (suppress),
    .seg    (glyph)
  );

  assign out7_d   = glyph;
  assign dp_out_d = ~cur_dp;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt_q      <= '0;
      digit_idx_q    <= '0;
      stage_value_q  <= '0;
      stage_dp_q     <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      pending_q      <= 1'b0;
      out7_q         <= SEG_BLANK;
      dp_out_q       <= 1'b1;
      en_q           <= '1;
      frame_done_q   <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      digit_idx_q    <= digit_idx_d;
      stage_value_q  <= stage_value_d;
      stage_dp_q     <= stage_dp_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      pending_q      <= pending_d;
      out7_q         <= out7_d;
      dp_out_q       <= dp_out_d;
      en_q           <= en_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign out7       = out7_q;
  assign dp_out     = dp_out_q;
  assign en_out     = en_q;
  assign frame_done = frame_done_q;

endmodule
